// File: rtl/instr_decoder_pkg.sv
// Shared definitions for the RV32I instruction decoder and its consumers.
// Holds the supported opcodes, the format-class encoding and the packed
// record of decoded fields that the output stage registers.
package instr_decoder_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Format class seen by the execute stage.
  typedef enum logic [2:0] {
    FmtR   = 3'd0,
    FmtI   = 3'd1,
    FmtS   = 3'd2,
    FmtB   = 3'd3,
    FmtU   = 3'd4,
    FmtJ   = 3'd5,
    FmtUnk = 3'd7
  } fmt_e;

  // Decoded fields held by the output register stage.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    fmt_e        fmt;
    logic [31:0] imm;
  } dec_t;

endpackage

// File: rtl/instr_decoder_if.sv
// Bus between the fetch side of the core and the decoder.
//   in_valid / instr_out : raw instruction word and its qualifier
//   out_valid, opcode, funct3, funct7, rs1, rs2, rd, fmt, imm, illegal :
//                          registered decode results
// master : the core side (drives the instruction, consumes the decode)
// slave  : the decoder
interface instr_decoder_if;

  logic        in_valid;
  logic [31:0] instr_out;
  logic        out_valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [2:0]  fmt;
  logic [31:0] imm;
  logic        illegal;

  modport master (
    output in_valid, instr_out,
    input  out_valid, opcode, funct3, funct7, rs1, rs2, rd, fmt, imm, illegal
  );

  modport slave (
    input  in_valid, instr_out,
    output out_valid, opcode, funct3, funct7, rs1, rs2, rd, fmt, imm, illegal
  );

endinterface

// File: rtl/instr_decoder_imm_gen.sv
// Purely combinational format-class and immediate generator.
//   instr_i : raw 32-bit RV32I instruction word
//   fmt_o   : format class selected by the opcode (FmtUnk for unsupported)
//   imm_o   : sign-extended immediate for that format (0 for R and unknown)
module instr_decoder_imm_gen
  import instr_decoder_pkg::*;
(
  input  logic [31:0] instr_i,
  output fmt_e        fmt_o,
  output logic [31:0] imm_o
);

  always_comb begin
    fmt_o = FmtUnk;
    imm_o = '0;
    case (instr_i[6:0])
      OP_R: begin
        fmt_o = FmtR;
      end
      // Shifts under OP_IMM keep the full I immediate; shamt is read from rs2.
      OP_LOAD, OP_IMM, OP_JALR: begin
        fmt_o = FmtI;
        imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OP_STORE: begin
        fmt_o = FmtS;
        imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OP_BRANCH: begin
        fmt_o = FmtB;
        imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt_o = FmtU;
        imm_o = {instr_i[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt_o = FmtJ;
        imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      end
      default: begin
        fmt_o = FmtUnk;
        imm_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/instr_decoder.sv
// RV32I instruction-field decoder with one registered output stage.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every output
//   bus   : instr_decoder_if.slave (in_valid/instr_out in, decoded fields out)
// A decode is captured on every clk edge with in_valid high; with in_valid low
// out_valid drops and the fields hold.
// Optional feature: define INSTR_DECODER_ILLEGAL_CHECK_EN to build and register
// the unsupported-encoding check; otherwise illegal is tied low.
module instr_decoder
  import instr_decoder_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  instr_decoder_if.slave bus
);

  fmt_e        gen_fmt;
  logic [31:0] gen_imm;

  instr_decoder_imm_gen u_imm_gen (
    .instr_i (bus.instr_out),
    .fmt_o   (gen_fmt),
    .imm_o   (gen_imm)
  );

  dec_t dec_d, dec_q;
  logic out_valid_d, out_valid_q;

  always_comb begin
    dec_d       = dec_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      dec_d.opcode = bus.instr_out[6:0];
      dec_d.funct3 = bus.instr_out[14:12];
      dec_d.funct7 = bus.instr_out[31:25];
      dec_d.rs1    = bus.instr_out[19:15];
      dec_d.rs2    = bus.instr_out[24:20];
      dec_d.rd     = bus.instr_out[11:7];
      dec_d.fmt    = gen_fmt;
      dec_d.imm    = gen_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      dec_q       <= dec_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.opcode    = dec_q.opcode;
  assign bus.funct3    = dec_q.funct3;
  assign bus.funct7    = dec_q.funct7;
  assign bus.rs1       = dec_q.rs1;
  assign bus.rs2       = dec_q.rs2;
  assign bus.rd        = dec_q.rd;
  assign bus.fmt       = dec_q.fmt;
  assign bus.imm       = dec_q.imm;

`ifdef INSTR_DECODER_ILLEGAL_CHECK_EN
  function automatic logic check_illegal(input logic [31:0] instr);
    logic [6:0] f7;
    logic [2:0] f3;
    logic       bad;
    f7  = instr[31:25];
    f3  = instr[14:12];
    bad = 1'b0;
    case (instr[6:0])
      OP_R: begin
        if (f7 != F7_BASE && f7 != F7_ALT) bad = 1'b1;
        // The alternate funct7 only exists for sub and sra.
        else if (f7 == F7_ALT && f3 != 3'b000 && f3 != 3'b101) bad = 1'b1;
      end
      OP_IMM: begin
        if (f3 == 3'b001 && f7 != F7_BASE) bad = 1'b1;
        else if (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT) bad = 1'b1;
      end
      OP_LOAD: begin
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) bad = 1'b1;
      end
      OP_STORE: begin
        if (f3 > 3'b010) bad = 1'b1;
      end
      OP_BRANCH: begin
        if (f3 == 3'b010 || f3 == 3'b011) bad = 1'b1;
      end
      OP_JALR: begin
        if (f3 != 3'b000) bad = 1'b1;
      end
      OP_LUI, OP_AUIPC, OP_JAL: begin
        bad = 1'b0;
      end
      default: begin
        bad = 1'b1;
      end
    endcase
    return bad;
  endfunction

  logic illegal_d, illegal_q;

  always_comb begin
    illegal_d = illegal_q;
    if (bus.in_valid) begin
      illegal_d = check_illegal(bus.instr_out);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: a vector table driven back-to-back
// through a scoreboard queue, plus hand sequences for hold and async reset.
module tb_instr_decoder;

  logic clk;
  logic rst_n;

  instr_decoder_if bus_if ();

  instr_decoder u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef INSTR_DECODER_ILLEGAL_CHECK_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];
  vec_t sb_q[$];

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one decode expected per edge while entries are queued.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (sb_q.size() > 0) begin
        vec_t e;
        string t;
        e = sb_q.pop_front();
        t = $sformatf("%h", e.instr);
        chk({t, ".out_valid"}, 32'(bus_if.out_valid), 32'd1);
        chk({t, ".opcode"},    32'(bus_if.opcode),    32'(e.opcode));
        chk({t, ".funct3"},    32'(bus_if.funct3),    32'(e.f3));
        chk({t, ".funct7"},    32'(bus_if.funct7),    32'(e.f7));
        chk({t, ".rs1"},       32'(bus_if.rs1),       32'(e.rs1));
        chk({t, ".rs2"},       32'(bus_if.rs2),       32'(e.rs2));
        chk({t, ".rd"},        32'(bus_if.rd),        32'(e.rd));
        chk({t, ".fmt"},       32'(bus_if.fmt),       32'(e.fmt));
        chk({t, ".imm"},       bus_if.imm,            e.imm);
        chk({t, ".illegal"},   32'(bus_if.illegal),   32'(e.ill & ILL_EN));
      end else begin
        chk("idle.out_valid", 32'(bus_if.out_valid), 32'd0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, ".out_valid"}, 32'(bus_if.out_valid), 32'd0);
    chk({tag, ".opcode"},    32'(bus_if.opcode),    32'd0);
    chk({tag, ".funct3"},    32'(bus_if.funct3),    32'd0);
    chk({tag, ".funct7"},    32'(bus_if.funct7),    32'd0);
    chk({tag, ".rs1"},       32'(bus_if.rs1),       32'd0);
    chk({tag, ".rs2"},       32'(bus_if.rs2),       32'd0);
    chk({tag, ".rd"},        32'(bus_if.rd),        32'd0);
    chk({tag, ".fmt"},       32'(bus_if.fmt),       32'd0);
    chk({tag, ".imm"},       bus_if.imm,            32'd0);
    chk({tag, ".illegal"},   32'(bus_if.illegal),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          instr          opc    f3    f7     rs1    rs2     rd     fmt   imm             ill
    vecs[0]  = '{32'hFFF00093, 7'h13, 3'd0, 7'h7F, 5'd0,  5'd31, 5'd1,  3'd1, 32'hFFFFFFFF, 1'b0};
    vecs[1]  = '{32'h0020A423, 7'h23, 3'd2, 7'h00, 5'd1,  5'd2,  5'd8,  3'd2, 32'h00000008, 1'b0};
    vecs[2]  = '{32'hFE000EE3, 7'h63, 3'd0, 7'h7F, 5'd0,  5'd0,  5'd29, 3'd3, 32'hFFFFFFFC, 1'b0};
    vecs[3]  = '{32'h123452B7, 7'h37, 3'd5, 7'h09, 5'd8,  5'd3,  5'd5,  3'd4, 32'h12345000, 1'b0};
    vecs[4]  = '{32'h001000EF, 7'h6F, 3'd0, 7'h00, 5'd0,  5'd1,  5'd1,  3'd5, 32'h00000800, 1'b0};
    vecs[5]  = '{32'h00000000, 7'h00, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  3'd7, 32'h00000000, 1'b1};
    vecs[6]  = '{32'h002081B3, 7'h33, 3'd0, 7'h00, 5'd1,  5'd2,  5'd3,  3'd0, 32'h00000000, 1'b0};
    vecs[7]  = '{32'h40209133, 7'h33, 3'd1, 7'h20, 5'd1,  5'd2,  5'd2,  3'd0, 32'h00000000, 1'b1};
    vecs[8]  = '{32'h40335293, 7'h13, 3'd5, 7'h20, 5'd6,  5'd3,  5'd5,  3'd1, 32'h00000403, 1'b0};
    vecs[9]  = '{32'h40331293, 7'h13, 3'd1, 7'h20, 5'd6,  5'd3,  5'd5,  3'd1, 32'h00000403, 1'b1};
    vecs[10] = '{32'hFF812083, 7'h03, 3'd2, 7'h7F, 5'd2,  5'd24, 5'd1,  3'd1, 32'hFFFFFFF8, 1'b0};
    vecs[11] = '{32'hFF813083, 7'h03, 3'd3, 7'h7F, 5'd2,  5'd24, 5'd1,  3'd1, 32'hFFFFFFF8, 1'b1};
    vecs[12] = '{32'h00009067, 7'h67, 3'd1, 7'h00, 5'd1,  5'd0,  5'd0,  3'd1, 32'h00000000, 1'b1};
    vecs[13] = '{32'h0020B423, 7'h23, 3'd3, 7'h00, 5'd1,  5'd2,  5'd8,  3'd2, 32'h00000008, 1'b1};
    vecs[14] = '{32'hFE002EE3, 7'h63, 3'd2, 7'h7F, 5'd0,  5'd0,  5'd29, 3'd3, 32'hFFFFFFFC, 1'b1};
    vecs[15] = '{32'hFFFFF517, 7'h17, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd10, 3'd4, 32'hFFFFF000, 1'b0};

    rst_n            = 1'b0;
    bus_if.in_valid  = 1'b1;
    bus_if.instr_out = 32'hFFF00093;
    #3;
    check_all_zero("reset0");
    #5;
    // A clock edge under reset must not load anything.
    check_all_zero("reset_edge");

    @(negedge clk);
    bus_if.in_valid = 1'b0;
    rst_n           = 1'b1;
    mon_en          = 1'b1;

    // Back-to-back stream through the scoreboard.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      bus_if.in_valid  = 1'b1;
      bus_if.instr_out = vecs[i].instr;
      sb_q.push_back(vecs[i]);
    end
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    mon_en = 1'b0;

    // Hold: in_valid low drops out_valid but keeps the jal fields.
    @(negedge clk);
    bus_if.in_valid  = 1'b1;
    bus_if.instr_out = 32'h001000EF;
    @(posedge clk); #1;
    chk("hold.pre_valid", 32'(bus_if.out_valid), 32'd1);
    @(negedge clk);
    bus_if.in_valid  = 1'b0;
    bus_if.instr_out = 32'hFFFFFFFF;
    @(posedge clk); #1;
    chk("hold.out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("hold.opcode",    32'(bus_if.opcode),    32'h6F);
    chk("hold.rd",        32'(bus_if.rd),        32'd1);
    chk("hold.fmt",       32'(bus_if.fmt),       32'd5);
    chk("hold.imm",       bus_if.imm,            32'h00000800);

    // Async reset mid-cycle while out_valid is high.
    @(negedge clk);
    bus_if.in_valid  = 1'b1;
    bus_if.instr_out = 32'hFFF00093;
    @(posedge clk); #1;
    chk("mid.pre_valid", 32'(bus_if.out_valid), 32'd1);
    chk("mid.pre_imm",   bus_if.imm,            32'hFFFFFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    rst_n           = 1'b1;
    @(posedge clk); #1;
    chk("post.out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("post.imm",       bus_if.imm,            32'd0);
    @(negedge clk);
    bus_if.in_valid  = 1'b1;
    bus_if.instr_out = 32'hFFF00093;
    @(posedge clk); #1;
    chk("redo.out_valid", 32'(bus_if.out_valid), 32'd1);
    chk("redo.imm",       bus_if.imm,            32'hFFFFFFFF);
    chk("redo.fmt",       32'(bus_if.fmt),       32'd1);
    @(negedge clk);
    bus_if.in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
